// File: rtl/filter_test_sequencer_if.sv
// rtl/filter_test_sequencer_if.sv - control, generator, sample and result signals of the delay-sweep sequencer
interface filter_test_sequencer_if #(
    parameter int DELAY_W    = 8,
    parameter int DATA_W     = 20,
    parameter int N_STEPS    = 4,
    parameter int WINDOW_CYC = 256
);
    localparam int STEP_W = $clog2(N_STEPS) + 1;
    localparam int IDX_W  = $clog2(WINDOW_CYC) + 1;

    logic               start;
    logic               abort;
    logic [DELAY_W-1:0] cfg_delay_base;
    logic [DELAY_W-1:0] cfg_delay_step;
    logic               cfg_overlay;
    logic               cfg_rate;
    logic               test_overlay;
    logic               test_rate;
    logic [DELAY_W-1:0] test_delay;
    logic [DATA_W-1:0]  filt_data;
    logic               res_valid;
    logic               res_ready;
    logic [STEP_W-1:0]  res_step;
    logic [DATA_W-1:0]  res_peak;
    logic [IDX_W-1:0]   res_peak_idx;
    logic               busy;
    logic               done;

    modport slave (
        input  start, abort, cfg_delay_base, cfg_delay_step, cfg_overlay, cfg_rate,
               filt_data, res_ready,
        output test_overlay, test_rate, test_delay, res_valid, res_step, res_peak,
               res_peak_idx, busy, done
    );

    modport master (
        output start, abort, cfg_delay_base, cfg_delay_step, cfg_overlay, cfg_rate,
               filt_data, res_ready,
        input  test_overlay, test_rate, test_delay, res_valid, res_step, res_peak,
               res_peak_idx, busy, done
    );
endinterface

// File: rtl/filter_test_sequencer.sv
// rtl/filter_test_sequencer.sv - steps the test generator through a delay sweep and reports the filter peak per step
module filter_test_sequencer #(
    parameter int DELAY_W    = 8,
    parameter int DATA_W     = 20,
    parameter int N_STEPS    = 4,
    parameter int SETTLE_CYC = 16,
    parameter int WINDOW_CYC = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    filter_test_sequencer_if.slave  bus
);
    localparam int STEP_W = $clog2(N_STEPS) + 1;
    localparam int IDX_W  = $clog2(WINDOW_CYC) + 1;
    localparam int MAXC   = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
    localparam int CNT_W  = $clog2(MAXC) + 1;

    typedef enum logic [2:0] {S_IDLE, S_CONFIG, S_SETTLE, S_CAPTURE, S_REPORT} state_t;

    state_t                    state_q, state_d;
    logic [STEP_W-1:0]         step_q, step_d;
    logic [DELAY_W-1:0]        acc_q, acc_d;
    logic [DELAY_W-1:0]        inc_q, inc_d;
    logic                      ov_q, ov_d;
    logic                      rt_q, rt_d;
    logic [DELAY_W-1:0]        tdel_q, tdel_d;
    logic                      tov_q, tov_d;
    logic                      trt_q, trt_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [DATA_W-1:0]  peak_q, peak_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      done_q, done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            acc_q   <= '0;
            inc_q   <= '0;
            ov_q    <= 1'b0;
            rt_q    <= 1'b0;
            tdel_q  <= '0;
            tov_q   <= 1'b0;
            trt_q   <= 1'b0;
            cnt_q   <= '0;
            peak_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            inc_q   <= inc_d;
            ov_q    <= ov_d;
            rt_q    <= rt_d;
            tdel_q  <= tdel_d;
            tov_q   <= tov_d;
            trt_q   <= trt_d;
            cnt_q   <= cnt_d;
            peak_q  <= peak_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        inc_d   = inc_q;
        ov_d    = ov_q;
        rt_d    = rt_q;
        tdel_d  = tdel_q;
        tov_d   = tov_q;
        trt_d   = trt_q;
        cnt_d   = cnt_q;
        peak_d  = peak_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    acc_d   = bus.cfg_delay_base;
                    inc_d   = bus.cfg_delay_step;
                    ov_d    = bus.cfg_overlay;
                    rt_d    = bus.cfg_rate;
                    step_d  = '0;
                    state_d = S_CONFIG;
                end
            end
            S_CONFIG: begin
                // acc_q already holds base + step*inc (mod 2^DELAY_W)
                tdel_d  = acc_q;
                tov_d   = ov_q;
                trt_d   = rt_q;
                cnt_d   = '0;
                peak_d  = {1'b1, {(DATA_W-1){1'b0}}};
                idx_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                if ($signed(bus.filt_data) > peak_q) begin
                    peak_d = $signed(bus.filt_data);
                    idx_d  = IDX_W'(cnt_q);
                end
                if (cnt_q == CNT_W'(WINDOW_CYC - 1)) begin
                    state_d = S_REPORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REPORT: begin
                if (bus.res_ready) begin
                    if (step_q == STEP_W'(N_STEPS - 1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        tdel_d  = '0;
                        tov_d   = 1'b0;
                        trt_d   = 1'b0;
                    end else begin
                        step_d  = step_q + STEP_W'(1);
                        acc_d   = acc_q + inc_q;
                        state_d = S_CONFIG;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // abort overrides everything, including a same-cycle handshake
        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            tdel_d  = '0;
            tov_d   = 1'b0;
            trt_d   = 1'b0;
        end
    end

    assign bus.test_delay   = tdel_q;
    assign bus.test_overlay = tov_q;
    assign bus.test_rate    = trt_q;
    assign bus.res_valid    = (state_q == S_REPORT);
    assign bus.res_step     = step_q;
    assign bus.res_peak     = peak_q;
    assign bus.res_peak_idx = idx_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = done_q;
endmodule

// File: tb/tb_filter_test_sequencer.sv
// tb/tb_filter_test_sequencer.sv - self-checking bench for filter_test_sequencer
module tb_filter_test_sequencer;
    localparam int DELAY_W    = 8;
    localparam int DATA_W     = 20;
    localparam int N_STEPS    = 4;
    localparam int SETTLE_CYC = 16;
    localparam int WINDOW_CYC = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    filter_test_sequencer_if #(.DELAY_W(DELAY_W), .DATA_W(DATA_W), .N_STEPS(N_STEPS),
                               .WINDOW_CYC(WINDOW_CYC)) bus ();

    filter_test_sequencer #(.DELAY_W(DELAY_W), .DATA_W(DATA_W), .N_STEPS(N_STEPS),
                            .SETTLE_CYC(SETTLE_CYC), .WINDOW_CYC(WINDOW_CYC)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     k     = 0;
    int     pat   = 4;
    longint cyc   = 0;

    typedef struct {
        logic [7:0]      base;
        logic [7:0]      inc;
        logic            ov;
        logic            rt;
        int              p;
        logic [3:0][7:0] d;
        int              peak;
        int              idx;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Edge n after the start edge: step window samples land on edges 18..273 (mod 274)
    function automatic int fval(input int p, input int n);
        int r;
        if (n < 18) return 9999;
        r = (n - 18) % 274;
        if (r >= 256) return 9999;
        case (p)
            0: return (r == 37 || r == 100) ? 300 : -5;
            1: return -524288;
            2: return r - 128;
            3: return (r == 0) ? 1000 : -1;
            default: return -5;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (bus.start) k = 0;
        else k++;
        #1 bus.filt_data = DATA_W'(fval(pat, k + 1));
    end

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_start(input logic [7:0] base, input logic [7:0] inc, input logic ov,
                            input logic rt, input logic rdy);
        @(negedge clk);
        bus.cfg_delay_base = base;
        bus.cfg_delay_step = inc;
        bus.cfg_overlay    = ov;
        bus.cfg_rate       = rt;
        bus.res_ready      = rdy;
        bus.start          = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        longint t_prev;
        bit     got;
        pat = v.p;
        do_start(v.base, v.inc, v.ov, v.rt, 1'b1);
        t_prev = cyc;
        for (int s = 0; s < N_STEPS; s++) begin
            wait_valid(got);
            chk($sformatf("v%0d_s%0d_valid", vi, s), got, 1);
            if (got) begin
                chk($sformatf("v%0d_s%0d_interval", vi, s), cyc - t_prev, (s == 0) ? 273 : 274);
                t_prev = cyc;
                chk($sformatf("v%0d_s%0d_step", vi, s), bus.res_step, s);
                chk($sformatf("v%0d_s%0d_delay", vi, s), bus.test_delay, v.d[s]);
                chk($sformatf("v%0d_s%0d_ov", vi, s), bus.test_overlay, v.ov);
                chk($sformatf("v%0d_s%0d_rt", vi, s), bus.test_rate, v.rt);
                chk($sformatf("v%0d_s%0d_peak", vi, s), $signed(bus.res_peak), v.peak);
                chk($sformatf("v%0d_s%0d_idx", vi, s), bus.res_peak_idx, v.idx);
                @(negedge clk);
                chk($sformatf("v%0d_s%0d_valid_drop", vi, s), bus.res_valid, 0);
                chk($sformatf("v%0d_s%0d_done", vi, s), bus.done, (s == N_STEPS - 1) ? 1 : 0);
                chk($sformatf("v%0d_s%0d_busy", vi, s), bus.busy, (s == N_STEPS - 1) ? 0 : 1);
            end
        end
        @(negedge clk);
        chk($sformatf("v%0d_done_pulse_end", vi), bus.done, 0);
        chk($sformatf("v%0d_idle_delay", vi), bus.test_delay, 0);
    endtask

    initial begin
        bit got;
        bit seen;

        vecs[0] = '{8'd10,  8'd5,   1'b1, 1'b0, 0, {8'd25,  8'd20,  8'd15,  8'd10},  300,     37};
        vecs[1] = '{8'd250, 8'd5,   1'b0, 1'b1, 1, {8'd9,   8'd4,   8'd255, 8'd250}, -524288, 0};
        vecs[2] = '{8'd0,   8'd64,  1'b1, 1'b1, 2, {8'd192, 8'd128, 8'd64,  8'd0},   127,     255};
        vecs[3] = '{8'd255, 8'd255, 1'b0, 1'b0, 3, {8'd252, 8'd253, 8'd254, 8'd255}, 1000,    0};

        // Reset with random inputs
        bus.start          = 1'($urandom);
        bus.abort          = 1'($urandom);
        bus.cfg_delay_base = 8'($urandom);
        bus.cfg_delay_step = 8'($urandom);
        bus.cfg_overlay    = 1'($urandom);
        bus.cfg_rate       = 1'($urandom);
        bus.res_ready      = 1'($urandom);
        repeat (4) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_delay", bus.test_delay, 0);
        chk("rst_ov_rt", {bus.test_overlay, bus.test_rate}, 0);
        chk("rst_res", {bus.res_step, bus.res_peak, bus.res_peak_idx}, 0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst_n     = 1'b1;
        seen      = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (bus.busy || bus.res_valid) seen = 1'b1;
        end
        chk("idle_50_cycles", seen, 0);

        // Full sweeps from the vector table
        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // Back-pressure in REPORT, then abort colliding with a handshake
        pat = 4;
        do_start(8'd40, 8'd2, 1'b1, 1'b0, 1'b0);
        wait_valid(got);
        chk("bp_valid", got, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_valid_%0d", i), bus.res_valid, 1);
            chk($sformatf("bp_hold_res_%0d", i), {bus.res_step, bus.res_peak, bus.res_peak_idx},
                {3'd0, 20'hFFFFB, 9'd0});
            chk($sformatf("bp_hold_delay_%0d", i), bus.test_delay, 40);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("bp_adv_valid", bus.res_valid, 0);
        chk("bp_adv_delay_cfg", bus.test_delay, 40);
        @(negedge clk);
        chk("bp_adv_delay_new", bus.test_delay, 42);
        wait_valid(got);
        chk("bp_s1_valid", got, 1);
        chk("bp_s1_step", bus.res_step, 1);
        bus.res_ready = 1'b1;
        bus.abort     = 1'b1;
        @(negedge clk);
        bus.abort     = 1'b0;
        chk("abort_hs_busy", bus.busy, 0);
        chk("abort_hs_valid", bus.res_valid, 0);
        chk("abort_hs_done", bus.done, 0);
        chk("abort_hs_test", {bus.test_delay, bus.test_overlay, bus.test_rate}, 0);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        chk("start_abort_idle", bus.busy, 0);

        // Abort in CAPTURE of step 2, then restart
        pat = 0;
        do_start(8'd100, 8'd20, 1'b1, 1'b1, 1'b1);
        for (int s = 0; s < 2; s++) begin
            wait_valid(got);
            chk($sformatf("ab_s%0d_valid", s), got, 1);
            @(negedge clk);
        end
        repeat (1 + SETTLE_CYC + 50) @(negedge clk);
        chk("ab_pre_busy", bus.busy, 1);
        chk("ab_pre_delay", bus.test_delay, 140);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("ab_busy", bus.busy, 0);
        chk("ab_delay", bus.test_delay, 0);
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (bus.res_valid || bus.done || bus.busy) seen = 1'b1;
        end
        chk("ab_quiet", seen, 0);
        do_start(8'd77, 8'd3, 1'b1, 1'b0, 1'b1);
        chk("rs_config_delay", bus.test_delay, 0);
        @(negedge clk);
        chk("rs_settle_delay", bus.test_delay, 77);
        wait_valid(got);
        chk("rs_valid", got, 1);
        chk("rs_step", bus.res_step, 0);
        chk("rs_peak", $signed(bus.res_peak), 300);
        @(negedge clk);
        repeat (5) @(negedge clk);
        chk("rs_settle_s1", {bus.busy, bus.res_step, bus.test_delay}, {1'b1, 3'd1, 8'd80});

        // Asynchronous reset in SETTLE
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_test", {bus.test_delay, bus.test_overlay, bus.test_rate}, 0);
        chk("arst_res", {bus.res_valid, bus.res_step, bus.res_peak, bus.res_peak_idx}, 0);
        chk("arst_done", bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_release_idle", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
